// File: rtl/buffer_seq_pkg.sv
// ============================================================================
// buffer_seq_pkg : shared types and constants for the buffer access sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package buffer_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ      = 3'd2,
    ST_FLUSH     = 3'd3,
    ST_FLUSH_ACK = 3'd4,
    ST_FINISH    = 3'd5
  } seq_state_t;

  localparam int unsigned BUFFER_DEPTH_DEFAULT = 64;

  localparam logic [1:0] SIZE_1B = 2'd0;
  localparam logic [1:0] SIZE_2B = 2'd1;
  localparam logic [1:0] SIZE_3B = 2'd2;
  localparam logic [1:0] SIZE_4B = 2'd3;

  // req_size encodes byte count minus one
  function automatic logic [2:0] size_to_count(input logic [1:0] size);
    return {1'b0, size} + 3'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_lane_mux.sv
// ============================================================================
// byte_lane_mux : picks the outgoing write byte and merges a read byte by lane
// Rev 1.0
// ============================================================================
`default_nettype none

module byte_lane_mux (
  input  logic [31:0] wdata_i,
  input  logic [1:0]  wr_sel_i,
  output logic [7:0]  wr_byte_o,
  input  logic [31:0] rd_word_i,
  input  logic [7:0]  rx_byte_i,
  input  logic [1:0]  rd_sel_i,
  output logic [31:0] rd_word_o
);

  always_comb begin
    wr_byte_o = wdata_i[8*wr_sel_i +: 8];
    rd_word_o = rd_word_i;
    rd_word_o[8*rd_sel_i +: 8] = rx_byte_i;
  end

endmodule

`default_nettype wire

// File: rtl/buffer_access_sequencer.sv
// ============================================================================
// buffer_access_sequencer : turns word accesses into byte strobes on the data
// buffer, with occupancy checks and flush arbitration.   Rev 1.0
// ============================================================================
`default_nettype none

module buffer_access_sequencer
  import buffer_seq_pkg::*;
#(
  parameter int unsigned BUFFER_DEPTH = BUFFER_DEPTH_DEFAULT,
  parameter int unsigned OCC_WIDTH    = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic [31:0]          req_wdata,
  output logic                 req_ready,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          rd_word,
  input  logic                 flush_req,
  output logic                 flush_ack,
  input  logic [OCC_WIDTH-1:0] buffer_occupancy,
  input  logic [7:0]           rx_data,
  output logic                 get_rx_data,
  output logic                 store_tx_data,
  output logic [7:0]           tx_data,
  output logic                 clear,
  output logic                 busy
);

  seq_state_t  state_q;
  logic [2:0]  count_q;
  logic [1:0]  idx_q;
  logic [31:0] wdata_q;
  logic [31:0] rd_word_q;
  logic [7:0]  tx_data_q;
  logic        store_q, get_q, clear_q, done_q, err_q, ack_q;

  logic [2:0]  w_count;
  logic        w_legal;
  logic        w_last;
  logic [1:0]  w_wr_sel;
  logic [31:0] w_wr_src;
  logic [7:0]  w_wr_byte;
  logic [31:0] rd_word_d;

  assign w_count = size_to_count(req_size);

  // occupancy sum is one bit wider so a full buffer cannot wrap to "legal"
  always_comb begin
    if (req_write)
      w_legal = (({1'b0, buffer_occupancy} + (OCC_WIDTH+1)'(w_count))
                 <= (OCC_WIDTH+1)'(BUFFER_DEPTH));
    else
      w_legal = (buffer_occupancy >= OCC_WIDTH'(w_count));
  end

  assign w_last   = (({1'b0, idx_q} + 3'd1) == count_q);
  assign w_wr_sel = (state_q == ST_IDLE) ? 2'd0 : idx_q + 2'd1;
  assign w_wr_src = (state_q == ST_IDLE) ? req_wdata : wdata_q;

  byte_lane_mux u_lane_mux (
    .wdata_i   (w_wr_src),
    .wr_sel_i  (w_wr_sel),
    .wr_byte_o (w_wr_byte),
    .rd_word_i (rd_word_q),
    .rx_byte_i (rx_data),
    .rd_sel_i  (idx_q),
    .rd_word_o (rd_word_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      rd_word_q <= '0;
      tx_data_q <= '0;
      store_q   <= 1'b0;
      get_q     <= 1'b0;
      clear_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush_req) begin
            clear_q <= 1'b1;
            state_q <= ST_FLUSH;
          end else if (req_valid) begin
            count_q <= w_count;
            wdata_q <= req_wdata;
            idx_q   <= '0;
            if (!w_legal) begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= ST_FINISH;
            end else if (req_write) begin
              store_q   <= 1'b1;
              tx_data_q <= w_wr_byte;
              state_q   <= ST_WRITE;
            end else begin
              rd_word_q <= '0;
              get_q     <= 1'b1;
              state_q   <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (w_last) begin
            store_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end else begin
            idx_q     <= idx_q + 2'd1;
            tx_data_q <= w_wr_byte;
          end
        end
        ST_READ: begin
          rd_word_q <= rd_word_d;
          if (w_last) begin
            get_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end
        ST_FLUSH: begin
          clear_q <= 1'b0;
          ack_q   <= 1'b1;
          state_q <= ST_FLUSH_ACK;
        end
        ST_FLUSH_ACK: begin
          ack_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_FINISH: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == ST_IDLE) && !flush_req;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign rd_word       = rd_word_q;
  assign flush_ack     = ack_q;
  assign get_rx_data   = get_q;
  assign store_tx_data = store_q;
  assign tx_data       = tx_data_q;
  assign clear         = clear_q;

endmodule

`default_nettype wire
